// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: FSM encoding, default error data and a width helper
// shared by the round-robin Wishbone arbiter and its picker.
package wb_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hdead_beef;

    // Index width for v entries, never below one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; the first requester at or
// after last+1 (mod N) wins, reported both one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] c;

    // Scan from the farthest candidate down so the nearest requester overwrites.
    always_comb begin
        idx_o = '0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = IW'((int'(last_i) + k) % N);
            if (req_i[c]) idx_o = c;
        end
        gnt_o        = '0;
        gnt_o[idx_o] = |req_i;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one Wishbone slave between N
// masters, holding each grant for a whole transaction, with a hung-cycle watchdog.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int          N         = 2,
    parameter int          AW        = 24,
    parameter int          TW        = 8,
    parameter int          TIMEOUT   = 200,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*AW-1:0] m_addr,
    input  logic [N*32-1:0] m_wdata,
    input  logic [N-1:0]    m_we,
    input  logic [N-1:0]    m_cyc,
    output logic [N-1:0]    m_ack,
    output logic [31:0]     m_rdata,
    output logic [AW-1:0]   s_addr,
    output logic [31:0]     s_wdata,
    output logic            s_we,
    output logic            s_cyc,
    input  logic            s_ack,
    input  logic [31:0]     s_rdata,
    output logic [N-1:0]    grant,
    output logic            err_stb,
    output logic [7:0]      err_cnt
);

    localparam int IW = clog2(N);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d, pick_gnt;
    logic [IW-1:0] gidx_q, gidx_d, last_q, last_d, pick_idx;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          busy, g_cyc, tmo, done;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i  (m_cyc),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    assign busy  = state_q == ST_BUSY;
    assign g_cyc = |(m_cyc & grant_q);
    // A real ack in the timeout cycle suppresses the watchdog.
    assign tmo   = busy && g_cyc && !s_ack && cnt_q == TW'(TIMEOUT - 1);
    assign done  = busy && g_cyc && (s_ack || tmo);

    assign s_cyc   = busy && g_cyc && !tmo;
    assign m_ack   = done ? grant_q : '0;
    assign m_rdata = !done ? '0 : s_ack ? s_rdata : ERR_RDATA;
    assign s_addr  = m_addr[int'(gidx_q) * AW +: AW];
    assign s_wdata = m_wdata[int'(gidx_q) * 32 +: 32];
    assign s_we    = m_we[gidx_q];
    assign grant   = grant_q;
    assign err_stb = tmo;
    assign err_cnt = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        cnt_d     = busy ? cnt_q + TW'(1) : '0;
        err_cnt_d = (tmo && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
        if (state_q == ST_IDLE && |m_cyc) begin
            state_d = ST_BUSY;
            grant_d = pick_gnt;
            gidx_d  = pick_idx;
            last_d  = pick_idx;
        end else if ((busy && !g_cyc) || (!busy && state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            grant_d = '0;
        end else if (done) begin
            state_d = ST_RELEASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IW'(N - 1);
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed scenarios plus random traffic, every cycle checked
// against a transaction-level reference model of the round-robin arbiter.
module tb_wb_rr_arbiter;

    localparam int          N       = 2;
    localparam int          AW      = 24;
    localparam int          TW      = 8;
    localparam int          TIMEOUT = 200;
    localparam logic [31:0] ERR     = 32'hdeadbeef;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] m_addr;
    logic [N*32-1:0] m_wdata;
    logic [N-1:0]    m_we, m_cyc, m_ack, grant;
    logic [31:0]     m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]   s_addr;
    logic            s_we, s_cyc, s_ack, err_stb;
    logic [7:0]      err_cnt;

    int n_chk = 0, n_fail = 0;
    int owner, last, age, errs, first, n;
    bit rel;
    logic [N-1:0] acked, prev_g, d_grant, d_ack;
    logic [31:0]  d_rd;
    logic         d_stb, d_scyc;
    logic [N-1:0] gq[$];

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N(N), .AW(AW), .TW(TW), .TIMEOUT(TIMEOUT), .ERR_RDATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
        .m_cyc(m_cyc), .m_ack(m_ack), .m_rdata(m_rdata), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_we(s_we), .s_cyc(s_cyc), .s_ack(s_ack),
        .s_rdata(s_rdata), .grant(grant), .err_stb(err_stb), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = N - 1; age = 0; errs = 0; rel = 0; acked = '0; prev_g = '0;
    endtask

    task automatic set_req(input int i);
        m_cyc[i]            = 1'b1;
        m_addr[i*AW +: AW]  = AW'($urandom);
        m_wdata[i*32 +: 32] = $urandom;
        m_we[i]             = 1'($urandom);
    endtask

    // One clock: compare at negedge, advance the model at posedge, return at posedge+1.
    task automatic step();
        logic [N-1:0] eg, ea;
        logic es, et, on;
        logic [31:0] er;
        @(negedge clk);
        eg = '0; ea = '0; es = 0; et = 0; on = 0; er = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            if (!rel) begin
                on        = m_cyc[owner];
                et        = on && !s_ack && age == TIMEOUT - 1;
                es        = on && !et;
                ea[owner] = on && (s_ack || et);
                er        = !on ? '0 : s_ack ? s_rdata : et ? ERR : '0;
            end
        end
        check("grant", grant, eg);
        check("s_cyc", s_cyc, es);
        check("m_ack", m_ack, ea);
        check("m_rdata", m_rdata, er);
        check("err_stb", err_stb, et);
        check("err_cnt", err_cnt, errs);
        if (es) begin
            check("s_addr", s_addr, m_addr[owner*AW +: AW]);
            check("s_wdata", s_wdata, m_wdata[owner*32 +: 32]);
            check("s_we", s_we, m_we[owner]);
        end
        d_grant = grant; d_ack = m_ack; d_rd = m_rdata; d_stb = err_stb; d_scyc = s_cyc;
        if (|grant && prev_g == '0) gq.push_back(grant);
        prev_g = grant;
        acked  = ea;
        @(posedge clk);
        if (owner < 0) begin
            for (int k = 1; k <= N; k++)
                if (owner < 0 && m_cyc[(last + k) % N]) owner = (last + k) % N;
            if (owner >= 0) begin
                last = owner;
                age  = 0;
            end
        end else if (rel || !on) begin
            owner = -1;
            rel   = 0;
        end else if (|ea) begin
            rel = 1;
            if (et && errs < 255) errs++;
        end else begin
            age++;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        m_addr = '0; m_wdata = '0; m_we = '0; m_cyc = '0; s_ack = 0; s_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", grant, 0);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single master, slave acks two cycles after s_cyc.
        set_req(0);
        s_rdata = 32'h12345678;
        step(); check("t1_idle_s_cyc", d_scyc, 0);
        step(); check("t1_latency", d_scyc, 1);
        step();
        s_ack = 1;
        step();
        check("t1_ack", d_ack, 2'b01);
        check("t1_rdata", d_rd, 32'h12345678);
        check("t1_grant", d_grant, 2'b01);
        s_ack = 0; m_cyc = '0;
        step(); step();

        // Both masters held: grants must alternate.
        gq.delete();
        first = (last + 1) % N;
        set_req(0); set_req(1); s_ack = 1;
        for (int i = 0; i < 40 && gq.size() < 4; i++) step();
        m_cyc = '0; s_ack = 0;
        step(); step();
        check("t2_count", gq.size(), 4);
        for (int i = 0; i < gq.size(); i++) check("t2_order", gq[i], 1 << ((first + i) % N));

        // Slave never acks: watchdog terminates.
        set_req(0);
        n = 0;
        for (int i = 0; i < 400 && d_ack == '0; i++) begin
            step();
            if (|d_grant) n++;
        end
        check("t3_latency", n, TIMEOUT);
        check("t3_ack", d_ack, 2'b01);
        check("t3_rdata", d_rd, ERR);
        check("t3_stb", d_stb, 1);
        m_cyc = '0;
        step();
        check("t3_stb_pulse", d_stb, 0);
        check("t3_err_cnt", err_cnt, 1);
        step();

        // Real ack in the very cycle the watchdog would fire.
        set_req(1);
        step();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        s_ack = 1; s_rdata = 32'hcafef00d;
        step();
        check("t4_ack", d_ack, 2'b10);
        check("t4_rdata", d_rd, 32'hcafef00d);
        check("t4_stb", d_stb, 0);
        s_ack = 0; m_cyc = '0;
        step();
        check("t4_err_cnt", err_cnt, 1);
        step();

        // Granted master aborts; pending master follows.
        set_req(1);
        step();
        set_req(0);
        step(); check("t5_grant", d_grant, 2'b10);
        m_cyc[1] = 1'b0;
        step();
        check("t5_s_cyc", d_scyc, 0);
        check("t5_no_ack", d_ack, 0);
        step(); step();
        check("t5_next", d_grant, 2'b01);

        // Asynchronous reset in the middle of a transaction.
        #3 rst_n = 1'b0;
        #1;
        check("t6_s_cyc", s_cyc, 0);
        check("t6_grant", grant, 0);
        check("t6_m_ack", m_ack, 0);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_rdata", m_rdata, 0);
        model_reset();
        m_cyc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0); set_req(1);
        step(); step();
        check("t6_first", d_grant, 2'b01);
        m_cyc = '0;
        step(); step(); step();

        // Random traffic with a stretch of unresponsive slave.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acked[i]) m_cyc[i] = 1'b0;
                else if (m_cyc[i]) begin
                    if (owner == i && !rel && $urandom % 300 == 0) m_cyc[i] = 1'b0;
                end else if ($urandom % 3 == 0) set_req(i);
            end
            s_ack   = !(c >= 1000 && c < 1500) && ($urandom % 4 == 0);
            s_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
